// File: rtl/gpu_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// gpu_frame_sequencer_if
// Bundles the host vertex-write bus and the GPU-facing frame/memory signals
// of the frame sequencer.
//   host_wr_en/addr/data   host -> sequencer  vertex write request
//   host_wr_ready          sequencer -> host  write accepted when en & ready
//   gpu_mem_wr_en/addr/data sequencer -> GPU  registered vertex memory write
//   gpu_vertex_count       sequencer -> GPU   latched vertex count (multiple of 4)
//   gpu_transform_matrix   sequencer -> GPU   active 4x4 matrix, row-major
//   gpu_start              sequencer -> GPU   one-cycle launch pulse
//   gpu_frame_end          GPU -> sequencer   1 when GPU idle, 0 during frame
// Modports: master = the sequencer, slave = the host/GPU environment.
// ---------------------------------------------------------------------------
interface gpu_frame_sequencer_if #(
    parameter int MAT_W  = 18,
    parameter int ADDR_W = 14
);
    logic                     host_wr_en;
    logic [ADDR_W-1:0]        host_wr_addr;
    logic [MAT_W-1:0]         host_wr_data;
    logic                     host_wr_ready;

    logic                     gpu_mem_wr_en;
    logic [ADDR_W-1:0]        gpu_mem_wr_addr;
    logic [MAT_W-1:0]         gpu_mem_wr_data;
    logic [31:0]              gpu_vertex_count;
    logic signed [MAT_W-1:0]  gpu_transform_matrix [16];
    logic                     gpu_start;
    logic                     gpu_frame_end;

    modport master (
        input  host_wr_en, host_wr_addr, host_wr_data, gpu_frame_end,
        output host_wr_ready, gpu_mem_wr_en, gpu_mem_wr_addr, gpu_mem_wr_data,
               gpu_vertex_count, gpu_transform_matrix, gpu_start
    );

    modport slave (
        output host_wr_en, host_wr_addr, host_wr_data, gpu_frame_end,
        input  host_wr_ready, gpu_mem_wr_en, gpu_mem_wr_addr, gpu_mem_wr_data,
               gpu_vertex_count, gpu_transform_matrix, gpu_start
    );
endinterface

// File: rtl/gpu_frame_sequencer.sv
// ---------------------------------------------------------------------------
// gpu_frame_sequencer
// Control block in front of the GPU pipeline. Owns the host write path into
// vertex memory, double-buffers the 4x4 transform matrix (shadow/active),
// launches single-shot or back-to-back frames, detects completion, counts
// frames and flags GPU stalls.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   cfg_vertex_count      vertices per frame (low 2 bits dropped at launch)
//   cfg_continuous        auto relaunch after each frame
//   cmd_start, cmd_stop   launch request (level, IDLE) / end continuous run
//   mat_wr_en/idx/data    shadow matrix element write
//   mat_commit            mark shadow pending for next launch
//   bus                   host write bus + GPU frame/memory signals
//   busy                  state != IDLE
//   frame_done            one-cycle pulse per completed frame
//   frame_count           completed frames, wraps
//   timeout_err, cfg_err  sticky errors, cleared by err_clear
// ---------------------------------------------------------------------------
module gpu_frame_sequencer #(
    parameter int MAT_W         = 18,
    parameter int ADDR_W        = 14,
    parameter int ACK_TIMEOUT   = 8,
    parameter int FRAME_TIMEOUT = 16777216,
    parameter int GAP_CYCLES    = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          cfg_vertex_count,
    input  logic                 cfg_continuous,
    input  logic                 cmd_start,
    input  logic                 cmd_stop,
    input  logic                 mat_wr_en,
    input  logic [3:0]           mat_wr_idx,
    input  logic [MAT_W-1:0]     mat_wr_data,
    input  logic                 mat_commit,
    gpu_frame_sequencer_if.master bus,
    output logic                 busy,
    output logic                 frame_done,
    output logic [15:0]          frame_count,
    output logic                 timeout_err,
    output logic                 cfg_err,
    input  logic                 err_clear
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_ACK,
        WAIT_DONE,
        GAP
    } state_t;

    state_t                  state_reg;
    logic [31:0]             cnt_reg;
    logic                    run_reg;
    logic                    pending_reg;
    logic                    gpu_start_reg;
    logic                    frame_done_reg;
    logic [15:0]             frame_count_reg;
    logic [31:0]             vertex_count_reg;
    logic                    timeout_err_reg;
    logic                    cfg_err_reg;

    logic signed [MAT_W-1:0] shadow_reg [16];
    logic signed [MAT_W-1:0] shadow_next [16];
    logic signed [MAT_W-1:0] active_reg [16];

    logic                    mem_wr_en_reg;
    logic [ADDR_W-1:0]       mem_wr_addr_reg;
    logic [MAT_W-1:0]        mem_wr_data_reg;

    logic [31:0]             masked_count;
    logic                    gap_done;
    logic                    launch_now;
    logic                    pending_next;
    logic                    host_ready;
    logic                    host_accept;

    assign masked_count = cfg_vertex_count & ~32'd3;
    assign gap_done     = (cnt_reg == 32'(GAP_CYCLES - 1));

    // A launch happens on the IDLE->LAUNCH or GAP->LAUNCH transition; both the
    // matrix apply and the vertex-count latch key off this single term.
    always_comb begin
        launch_now = 1'b0;
        case (state_reg)
            IDLE:    launch_now = cmd_start && (masked_count != 32'd0);
            GAP:     launch_now = !cmd_stop && gap_done && (masked_count != 32'd0);
            default: launch_now = 1'b0;
        endcase
    end

    // A commit arriving in the launch cycle still counts for that launch.
    assign pending_next = pending_reg | mat_commit;

    // Shadow view including a same-cycle element write, so a write issued
    // together with mat_commit (or with the launch) is part of what gets applied.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_shadow
            assign shadow_next[gi] = (mat_wr_en && (mat_wr_idx == 4'(gi)))
                                     ? $signed(mat_wr_data) : shadow_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                shadow_reg[i] <= '0;
                active_reg[i] <= '0;
            end
            pending_reg <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                shadow_reg[i] <= shadow_next[i];
            end
            if (launch_now) begin
                if (pending_next) begin
                    for (int i = 0; i < 16; i++) begin
                        active_reg[i] <= shadow_next[i];
                    end
                end
                pending_reg <= 1'b0;
            end else if (mat_commit) begin
                pending_reg <= 1'b1;
            end
        end
    end

    // Host write path: only open while idle so vertex memory is stable during
    // a frame. A write accepted in the launch cycle lands alongside gpu_start.
    assign host_ready  = (state_reg == IDLE);
    assign host_accept = bus.host_wr_en && host_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_wr_en_reg   <= 1'b0;
            mem_wr_addr_reg <= '0;
            mem_wr_data_reg <= '0;
        end else begin
            mem_wr_en_reg <= host_accept;
            if (host_accept) begin
                mem_wr_addr_reg <= bus.host_wr_addr;
                mem_wr_data_reg <= bus.host_wr_data;
            end
        end
    end

    // Frame control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            run_reg          <= 1'b0;
            gpu_start_reg    <= 1'b0;
            frame_done_reg   <= 1'b0;
            frame_count_reg  <= '0;
            vertex_count_reg <= '0;
            timeout_err_reg  <= 1'b0;
            cfg_err_reg      <= 1'b0;
        end else begin
            gpu_start_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            cnt_reg        <= cnt_reg + 32'd1;

            case (state_reg)
                IDLE: begin
                    if (cmd_start) begin
                        if (launch_now) begin
                            vertex_count_reg <= masked_count;
                            run_reg          <= cfg_continuous && !cmd_stop;
                            gpu_start_reg    <= 1'b1;
                            state_reg        <= LAUNCH;
                        end else begin
                            cfg_err_reg <= 1'b1;
                        end
                    end
                end

                LAUNCH: begin
                    if (cmd_stop) run_reg <= 1'b0;
                    cnt_reg   <= '0;
                    state_reg <= WAIT_ACK;
                end

                WAIT_ACK: begin
                    if (cmd_stop) run_reg <= 1'b0;
                    if (!bus.gpu_frame_end) begin
                        cnt_reg   <= '0;
                        state_reg <= WAIT_DONE;
                    end else if (cnt_reg == 32'(ACK_TIMEOUT - 1)) begin
                        timeout_err_reg <= 1'b1;
                        run_reg         <= 1'b0;
                        state_reg       <= IDLE;
                    end
                end

                WAIT_DONE: begin
                    if (cmd_stop) run_reg <= 1'b0;
                    if (bus.gpu_frame_end) begin
                        frame_done_reg  <= 1'b1;
                        frame_count_reg <= frame_count_reg + 16'd1;
                        cnt_reg         <= '0;
                        state_reg       <= (run_reg && !cmd_stop) ? GAP : IDLE;
                    end else if (cnt_reg == 32'(FRAME_TIMEOUT - 1)) begin
                        timeout_err_reg <= 1'b1;
                        run_reg         <= 1'b0;
                        state_reg       <= IDLE;
                    end
                end

                GAP: begin
                    if (cmd_stop) begin
                        run_reg   <= 1'b0;
                        state_reg <= IDLE;
                    end else if (gap_done) begin
                        if (launch_now) begin
                            vertex_count_reg <= masked_count;
                            gpu_start_reg    <= 1'b1;
                            state_reg        <= LAUNCH;
                        end else begin
                            cfg_err_reg <= 1'b1;
                            run_reg     <= 1'b0;
                            state_reg   <= IDLE;
                        end
                    end
                end

                default: state_reg <= IDLE;
            endcase

            // Clearing wins over a same-cycle error set (later NBA overrides).
            if (err_clear) begin
                timeout_err_reg <= 1'b0;
                cfg_err_reg     <= 1'b0;
            end
        end
    end

    assign bus.host_wr_ready        = host_ready;
    assign bus.gpu_mem_wr_en        = mem_wr_en_reg;
    assign bus.gpu_mem_wr_addr      = mem_wr_addr_reg;
    assign bus.gpu_mem_wr_data      = mem_wr_data_reg;
    assign bus.gpu_vertex_count     = vertex_count_reg;
    assign bus.gpu_transform_matrix = active_reg;
    assign bus.gpu_start            = gpu_start_reg;

    assign busy        = (state_reg != IDLE);
    assign frame_done  = frame_done_reg;
    assign frame_count = frame_count_reg;
    assign timeout_err = timeout_err_reg;
    assign cfg_err     = cfg_err_reg;

endmodule

// File: tb/tb_gpu_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gpu_frame_sequencer
// Directed bench for gpu_frame_sequencer. Inputs are driven and outputs are
// sampled on the falling clock edge. A small GPU model answers gpu_start.
// ---------------------------------------------------------------------------
module tb_gpu_frame_sequencer;

    localparam int MAT_W  = 18;
    localparam int ADDR_W = 14;

    logic              clk;
    logic              reset_n;
    logic [31:0]       cfg_vertex_count;
    logic              cfg_continuous;
    logic              cmd_start;
    logic              cmd_stop;
    logic              mat_wr_en;
    logic [3:0]        mat_wr_idx;
    logic [MAT_W-1:0]  mat_wr_data;
    logic              mat_commit;
    logic              busy;
    logic              frame_done;
    logic [15:0]       frame_count;
    logic              timeout_err;
    logic              cfg_err;
    logic              err_clear;

    gpu_frame_sequencer_if #(.MAT_W(MAT_W), .ADDR_W(ADDR_W)) bus ();

    gpu_frame_sequencer #(
        .MAT_W(MAT_W), .ADDR_W(ADDR_W), .ACK_TIMEOUT(8),
        .FRAME_TIMEOUT(1000), .GAP_CYCLES(16)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_vertex_count(cfg_vertex_count), .cfg_continuous(cfg_continuous),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .mat_wr_en(mat_wr_en), .mat_wr_idx(mat_wr_idx), .mat_wr_data(mat_wr_data),
        .mat_commit(mat_commit), .bus(bus),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
        .timeout_err(timeout_err), .cfg_err(cfg_err), .err_clear(err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_count = 0;
    int gpu_mode = 0;   // 0 normal frame, 1 never lowers frame_end, 2 stuck low
    int frame_len = 50;

    always @(posedge clk) cyc++;

    always @(negedge clk) if (bus.gpu_start === 1'b1) start_count++;

    // GPU model: frame_end drops two cycles after the start pulse is seen and
    // stays low for frame_len cycles.
    initial begin
        bus.gpu_frame_end = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.gpu_start === 1'b1 && gpu_mode != 1) begin
                @(negedge clk);
                @(negedge clk);
                bus.gpu_frame_end = 1'b0;
                if (gpu_mode == 2) begin
                    wait (gpu_mode != 2);
                end else begin
                    repeat (frame_len) @(negedge clk);
                end
                bus.gpu_frame_end = 1'b1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a launch request for one cycle; the pulse must appear one cycle later.
    task automatic launch(input string tag, input logic [31:0] count, input logic cont);
        cfg_vertex_count = count;
        cfg_continuous   = cont;
        cmd_start        = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        chk(tag, bus.gpu_start, 1);
    endtask

    task automatic wait_done(input int max_cyc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < max_cyc);
    endtask

    task automatic wait_start(input int max_cyc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.gpu_start !== 1'b1 && n < max_cyc);
    endtask

    int n;
    int s0, s1, s2;
    int bad;

    initial begin
        reset_n = 1'b0; cfg_vertex_count = '0; cfg_continuous = 1'b0;
        cmd_start = 1'b0; cmd_stop = 1'b0; mat_wr_en = 1'b0; mat_wr_idx = '0;
        mat_wr_data = '0; mat_commit = 1'b0; err_clear = 1'b0;
        bus.host_wr_en = 1'b0; bus.host_wr_addr = '0; bus.host_wr_data = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_ready", bus.host_wr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_start", bus.gpu_start, 0);
        chk("rst_fcount", frame_count, 0);
        chk("rst_errs", {timeout_err, cfg_err}, 0);
        chk("rst_memwr", bus.gpu_mem_wr_en, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single frame with host writes; the last write coincides with launch
        for (int i = 0; i < 8; i++) begin
            bus.host_wr_en   = 1'b1;
            bus.host_wr_addr = ADDR_W'(i);
            bus.host_wr_data = MAT_W'(i);
            if (i == 7) begin
                cfg_vertex_count = 32'd10;
                cmd_start = 1'b1;
            end
            @(negedge clk);
            chk("mem_wr_en", bus.gpu_mem_wr_en, 1);
            chk("mem_wr_addr", bus.gpu_mem_wr_addr, i);
            chk("mem_wr_data", bus.gpu_mem_wr_data, i);
        end
        bus.host_wr_en = 1'b0;
        cmd_start = 1'b0;
        chk("f1_start", bus.gpu_start, 1);
        chk("f1_vcount", bus.gpu_vertex_count, 8);
        chk("f1_ready_busy", bus.host_wr_ready, 0);
        wait_done(200, n);
        chk("f1_done_lat", n, 53);
        chk("f1_fcount", frame_count, 1);
        chk("f1_idle_ready", bus.host_wr_ready, 1);
        @(negedge clk);
        chk("f1_done_pulse", frame_done, 0);

        // Matrix commit mid-frame is deferred to the next launch
        frame_len = 30;
        launch("m1_start", 32'd16, 1'b0);
        repeat (5) @(negedge clk);
        mat_wr_en = 1'b1; mat_wr_idx = 4'd5; mat_wr_data = 18'h00080; mat_commit = 1'b1;
        @(negedge clk);
        mat_wr_en = 1'b0; mat_commit = 1'b0;
        chk("m1_hold", bus.gpu_transform_matrix[5], 0);
        wait_done(200, n);
        chk("m1_hold_end", bus.gpu_transform_matrix[5], 0);
        @(negedge clk);
        launch("m2_start", 32'd16, 1'b0);
        chk("m2_applied", bus.gpu_transform_matrix[5], 32'h80);
        wait_done(200, n);
        @(negedge clk);
        mat_commit = 1'b1;
        @(negedge clk);
        mat_commit = 1'b0;
        launch("m3_start", 32'd16, 1'b0);
        chk("m3_e5", bus.gpu_transform_matrix[5], 32'h80);
        chk("m3_e0", bus.gpu_transform_matrix[0], 0);
        wait_done(200, n);
        chk("m3_fcount", frame_count, 4);
        @(negedge clk);

        // Continuous mode: three frames, stop during the third
        frame_len = 20;
        launch("c_start0", 32'd20, 1'b1);
        s0 = cyc;
        wait_start(100, n);
        chk("c_start1", bus.gpu_start, 1);
        s1 = cyc;
        wait_start(100, n);
        chk("c_start2", bus.gpu_start, 1);
        s2 = cyc;
        repeat (10) @(negedge clk);
        cmd_stop = 1'b1;
        @(negedge clk);
        cmd_stop = 1'b0;
        wait_done(100, n);
        chk("c_done3", frame_done, 1);
        chk("c_space1", s1 - s0, 39);
        chk("c_space2", s2 - s1, 39);
        chk("c_fcount", frame_count, 7);
        @(negedge clk);
        chk("c_idle", busy, 0);
        repeat (60) @(negedge clk);

        // Start and stop together: single frame despite continuous config
        cmd_stop = 1'b1;
        launch("ss_start", 32'd8, 1'b1);
        cmd_stop = 1'b0;
        wait_done(100, n);
        repeat (60) @(negedge clk);
        chk("ss_starts", start_count, 8);
        chk("ss_fcount", frame_count, 8);

        // Zero masked count is rejected; err_clear wins over a same-cycle set
        cfg_vertex_count = 32'd3;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        chk("cfg_err_set", cfg_err, 1);
        chk("cfg_no_start", bus.gpu_start, 0);
        chk("cfg_idle", busy, 0);
        cmd_start = 1'b1; err_clear = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0; err_clear = 1'b0;
        chk("cfg_err_clr", cfg_err, 0);

        // GPU never acknowledges
        gpu_mode = 1;
        launch("ack_start", 32'd8, 1'b0);
        repeat (7) @(negedge clk);
        chk("ack_pre_err", timeout_err, 0);
        chk("ack_pre_busy", busy, 1);
        repeat (2) @(negedge clk);
        chk("ack_err", timeout_err, 1);
        chk("ack_idle", busy, 0);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("ack_clr", timeout_err, 0);

        // frame_end stuck low
        gpu_mode = 2;
        launch("ft_start", 32'd8, 1'b0);
        repeat (995) @(negedge clk);
        chk("ft_pre_busy", busy, 1);
        chk("ft_pre_err", timeout_err, 0);
        repeat (15) @(negedge clk);
        chk("ft_err", timeout_err, 1);
        chk("ft_idle", busy, 0);
        chk("ft_fcount", frame_count, 8);
        gpu_mode = 0;
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        @(negedge clk);
        chk("total_starts", start_count, 10);

        // Reset mid-frame with a host write held
        frame_len = 40;
        launch("rs_start", 32'd8, 1'b0);
        bus.host_wr_en = 1'b1; bus.host_wr_addr = 14'd100; bus.host_wr_data = 18'h2AAAA;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.host_wr_ready !== 1'b0 || bus.gpu_mem_wr_en !== 1'b0) bad++;
        end
        chk("rs_blocked", bad, 0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rs_busy", busy, 0);
        chk("rs_ready", bus.host_wr_ready, 1);
        chk("rs_memwr", bus.gpu_mem_wr_en, 0);
        chk("rs_fcount", frame_count, 0);
        chk("rs_vcount", bus.gpu_vertex_count, 0);
        chk("rs_matrix", bus.gpu_transform_matrix[5], 0);
        chk("rs_start", bus.gpu_start, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rs_wr_after", bus.gpu_mem_wr_en, 1);
        chk("rs_wr_addr", bus.gpu_mem_wr_addr, 100);
        bus.host_wr_en = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
